trim_sar_cal: RTL
=================

# trim_sar_cal

Digital successive-approximation calibration controller for the 5-bit resistor-divider trim. It enables the trimmed divider and its comparator, then walks the trim code MSB-first. After each trial code it waits for the analog nodes to settle and majority-votes the synchronized comparator decision. It sits directly upstream of the divider's `trim` input and downstream of the comparator `out`.

## Interface
Parameters:
- `TRIM_W`, 5: trim code width.
- `TRIM_DEF`, 5'b10000: trim code driven out of reset, after abort, and while idle before any calibration.
- `SETTLE_CYC`, 16: wait cycles after enable and after each trial code; legal range SYNC_STAGES+1..255.
- `SYNC_STAGES`, 2: flops in the `comp_out` synchronizer; legal range 2..4.
- `NSAMP`, 3: comparator samples per bit; odd, 1..7.
- `KEEP_VAL`, 1: voted comparator value that keeps the trial bit.

Ports:
- `clk` input 1: calibration clock.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: level-sampled request; acted on only in IDLE or DONE.
- `abort` input 1: cancels calibration in any state.
- `comp_out` input 1: comparator decision, asynchronous to `clk`.
- `trim_ovr_en` input 1: selects `trim_ovr` onto `trim`.
- `trim_ovr` input TRIM_W: test/OTP override code.
- `div_en` output 1: divider enable.
- `comp_en` output 1: comparator enable.
- `trim` output TRIM_W: code to the divider.
- `busy` output 1: calibration in progress.
- `done` output 1: result valid.

## Operation
- `trim = trim_ovr_en ? trim_ovr : trim_reg` is combinational. The override never disturbs the FSM or `trim_reg`.
- The synchronizer output `cs` is a SYNC_STAGES-flop chain. Only `cs` is sampled.
- FSM states are IDLE, ENABLE, SET_BIT, SETTLE, SAMPLE, DECIDE and DONE. A bit index `b` runs from TRIM_W-1 down to 0.
- **IDLE / DONE + start:** go to ENABLE.
  - Set `trim_reg` = 0, `busy` = 1, `done` = 0, `div_en` = `comp_en` = 1.
  - Set `b` = TRIM_W-1 and load the wait counter with SETTLE_CYC.
- **ENABLE:** decrement the counter. At 1, go to SET_BIT.
- **SET_BIT:** set `trim_reg[b]` = 1, load the counter with SETTLE_CYC, go to SETTLE.
- **SETTLE:** decrement. At 1, clear the vote counter and go to SAMPLE.
- **SAMPLE:** one cycle per sample, NSAMP cycles.
  - On each cycle, add 1 to the vote count when `cs` == KEEP_VAL.
  - The vote count is 3 bits wide and saturates at NSAMP.
- **DECIDE:** if votes < (NSAMP+1)/2, clear `trim_reg[b]`.
  - If `b` == 0, go to DONE. Otherwise decrement `b` and go to SET_BIT.
- **DONE:** `busy` = 0, `done` = 1, `comp_en` = 0; `div_en` stays 1; `trim_reg` holds the result.
- **start while busy:** ignored.
- **abort:** from any non-IDLE state, go to IDLE next edge.
  - `trim_reg` = TRIM_DEF; `busy`, `done`, `div_en` and `comp_en` = 0.
  - abort has priority over start in the same cycle.
- **IDLE without start:** outputs hold. `div_en` = 0 in IDLE.

## Timing
- **Reset values:** `trim_reg` = TRIM_DEF; `busy`, `done`, `div_en` and `comp_en` = 0; FSM in IDLE; synchronizer and counters at 0.
- **rst mid-calibration:** all of the above apply immediately. No partial code is retained.
- `start` is seen high at rising edge k. From edge k: `busy`, `div_en` and `comp_en` = 1, and `trim` = 0.
- **Per bit:**
  - SET_BIT takes 1 cycle, SETTLE takes SETTLE_CYC, SAMPLE takes NSAMP, DECIDE takes 1.
  - The trial bit becomes visible on `trim` the edge after SET_BIT is entered.
- **Total busy time:** SETTLE_CYC + TRIM_W×(SETTLE_CYC+NSAMP+2) cycles. With defaults: 16 + 5×21 = 121.
  - `done` rises at edge k+121, in the same edge that `busy` falls.
- **Sampling window:** the SETTLE_CYC ≥ SYNC_STAGES+1 rule guarantees `cs` reflects the trial code before SAMPLE.
- `done` is a level. It clears at the start edge of the next calibration, on abort, or on rst.
- **start held high continuously:** a new calibration starts one cycle after DONE is entered.

## Test plan
- **Nominal:** bench comparator drives `comp_out` = (trim ≤ 19); pulse `start`.
  - Trial codes are 16, 24, 20, 18, 19.
  - Result `trim` = 5'b10011; `done` at start+121 cycles; `comp_en` = 0 and `div_en` = 1 after.
- **Rails:** `comp_out` stuck 0 gives result 0. `comp_out` stuck 1 gives result 31. Both reach `done` after 121 cycles.
- **Noise:** same model as Nominal, but force one wrong sample in each bit's SAMPLE window. Result is still 19 (majority 2 of 3).
- **Abort / start interaction:**
  - Assert `abort` during bit 2 SETTLE: next edge `trim` = 5'b10000, all flags 0, IDLE.
  - A `start` pulse during `busy` does not restart or extend the 121-cycle run.
- **Reset:** assert `rst` asynchronously mid-SAMPLE. Outputs go to reset values without a clock edge. A subsequent `start` runs a full 121-cycle calibration.
- **Override:** `trim_ovr_en` = 1, `trim_ovr` = 5'b00111 during calibration. `trim` = 7 throughout. Dropping the override after `done` shows the calibrated result.

Source files
------------

// File: rtl/trim_sar_cal_if.sv
`default_nettype none
// ============================================================================
// Module      : trim_sar_cal_if
// Description : Control, comparator and trim bundle between the SAR trim
//               calibration controller and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface trim_sar_cal_if #(
    parameter int TRIM_W = 5
);
    logic              start;
    logic              abort;
    logic              comp_out;
    logic              trim_ovr_en;
    logic [TRIM_W-1:0] trim_ovr;
    logic              div_en;
    logic              comp_en;
    logic [TRIM_W-1:0] trim;
    logic              busy;
    logic              done;

    // Environment side: requests, comparator decision and override in.
    modport master (
        output start, abort, comp_out, trim_ovr_en, trim_ovr,
        input  div_en, comp_en, trim, busy, done
    );

    // Controller side.
    modport slave (
        input  start, abort, comp_out, trim_ovr_en, trim_ovr,
        output div_en, comp_en, trim, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/trim_sar_cal.sv
`default_nettype none
// ============================================================================
// Module      : trim_sar_cal
// Description : Successive-approximation calibration of the resistor-divider
//               trim code. Enables divider and comparator, then walks the
//               code MSB-first, settling after every trial and majority-voting
//               the synchronized comparator decision.
// Revision    : 1.0 - initial release
// ============================================================================
module trim_sar_cal #(
    parameter int                 TRIM_W      = 5,
    parameter logic [TRIM_W-1:0]  TRIM_DEF    = 5'b10000,
    parameter int                 SETTLE_CYC  = 16,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 NSAMP       = 3,
    parameter logic               KEEP_VAL    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    trim_sar_cal_if.slave bus
);

    localparam int                BW        = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [BW-1:0]     TOP_IDX   = BW'(TRIM_W - 1);
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [7:0]        NSAMP_LD  = 8'(NSAMP);
    localparam logic [2:0]        VOTE_MAX  = 3'(NSAMP);
    localparam logic [2:0]        VOTE_THR  = 3'((NSAMP + 1) / 2);
    localparam logic [TRIM_W-1:0] ONE       = {{(TRIM_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENABLE  = 3'd1,
        S_SET_BIT = 3'd2,
        S_SETTLE  = 3'd3,
        S_SAMPLE  = 3'd4,
        S_DECIDE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [BW-1:0]       r_bit, w_bit_nxt;
    logic [2:0]          r_votes, w_votes_nxt;
    logic [TRIM_W-1:0]   r_trim, w_trim_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_div_en, w_div_en_nxt;
    logic                r_comp_en, w_comp_en_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                w_cs;
    logic [TRIM_W-1:0]   w_bit_mask;

    assign w_cs       = r_sync[SYNC_STAGES-1];
    assign w_bit_mask = ONE << r_bit;

    // Bring the asynchronous comparator decision into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.comp_out};
        end
    end

    // State and datapath registers; reset discards any partial code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_votes   <= '0;
            r_trim    <= TRIM_DEF;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div_en  <= 1'b0;
            r_comp_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_votes   <= w_votes_nxt;
            r_trim    <= w_trim_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_div_en  <= w_div_en_nxt;
            r_comp_en <= w_comp_en_nxt;
        end
    end

    // Next-state and next-output logic; abort outranks everything else.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_votes_nxt   = r_votes;
        w_trim_nxt    = r_trim;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_div_en_nxt  = r_div_en;
        w_comp_en_nxt = r_comp_en;

        if (bus.abort) begin
            // In IDLE an abort simply suppresses a simultaneous start.
            if (r_state != S_IDLE) begin
                w_state_nxt   = S_IDLE;
                w_trim_nxt    = TRIM_DEF;
                w_busy_nxt    = 1'b0;
                w_done_nxt    = 1'b0;
                w_div_en_nxt  = 1'b0;
                w_comp_en_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_state_nxt   = S_ENABLE;
                        w_trim_nxt    = '0;
                        w_busy_nxt    = 1'b1;
                        w_done_nxt    = 1'b0;
                        w_div_en_nxt  = 1'b1;
                        w_comp_en_nxt = 1'b1;
                        w_bit_nxt     = TOP_IDX;
                        w_cnt_nxt     = SETTLE_LD;
                    end
                end
                S_ENABLE: begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_SET_BIT;
                    end
                end
                S_SET_BIT: begin
                    w_trim_nxt  = r_trim | w_bit_mask;
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = S_SETTLE;
                end
                S_SETTLE: begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_votes_nxt = '0;
                        w_cnt_nxt   = NSAMP_LD;
                        w_state_nxt = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if ((w_cs == KEEP_VAL) && (r_votes < VOTE_MAX)) begin
                        w_votes_nxt = r_votes + 3'd1;
                    end
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (r_votes < VOTE_THR) begin
                        w_trim_nxt = r_trim & ~w_bit_mask;
                    end
                    if (r_bit == '0) begin
                        w_state_nxt   = S_DONE;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_comp_en_nxt = 1'b0;
                    end else begin
                        w_bit_nxt   = r_bit - 1'b1;
                        w_state_nxt = S_SET_BIT;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // The override only steers the output mux, never the calibration itself.
    assign bus.trim    = bus.trim_ovr_en ? bus.trim_ovr : r_trim;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.div_en  = r_div_en;
    assign bus.comp_en = r_comp_en;

endmodule
`default_nettype wire
